// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-port round-robin arbiter.
// rr_pick scans the ports starting just after the last granted one.
package arb_pkg;

    localparam int ARB_PORTS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        // Offset 4 wraps back to last itself, so a lone repeat requester is still served.
        for (int k = 1; k <= ARB_PORTS; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4to1_comb.sv
// Combinational 4:1 byte multiplexer feeding the arbiter output register.
module mux_4to1_comb (
    input  logic [1:0] sel,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    output logic [7:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter granting one of four valid/ready requesters per burst and
// steering its bytes through a 4:1 mux into a single registered output stage.
module mux_4to1_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_valid,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic [7:0] in_data3,
    input  logic [3:0] in_last,
    output logic [3:0] in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [1:0] out_src,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic [1:0] last_grant_reg, last_grant_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;
    logic       out_valid_reg, out_valid_next;
    logic [7:0] out_data_reg, out_data_next;
    logic       out_last_reg, out_last_next;
    logic [1:0] out_src_reg, out_src_next;

    logic [7:0] mux_data;
    logic       sel_ready;
    logic       accept;
    logic       load_last;

    mux_4to1_comb u_mux (
        .sel (sel_reg),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (mux_data)
    );

    // Ready depends only on state and the output stage, never on in_valid.
    assign sel_ready = (state_reg == LOCKED) && (!out_valid_reg || out_ready);
    assign accept    = sel_ready && in_valid[sel_reg];
    assign load_last = in_last[sel_reg] || (beat_cnt_reg == BURST_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < ARB_PORTS; gi++) begin : g_ready
            assign in_ready[gi] = sel_ready && (sel_reg == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        out_src_next    = out_src_reg;

        case (state_reg)
            IDLE: begin
                if (|in_valid) begin
                    sel_next      = rr_pick(in_valid, last_grant_reg);
                    beat_cnt_next = 4'd0;
                    state_next    = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                    if (load_last) begin
                        last_grant_next = sel_reg;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh load wins over the drain of the previous beat.
        if (accept) begin
            out_valid_next = 1'b1;
            out_data_next  = mux_data;
            out_last_next  = load_last;
            out_src_next   = sel_reg;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= 2'd0;
            last_grant_reg <= 2'd3;
            beat_cnt_reg   <= 4'd0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 8'h00;
            out_last_reg   <= 1'b0;
            out_src_reg    <= 2'd0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            out_src_reg    <= out_src_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg == LOCKED);

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Directed bench for the round-robin arbiter: per-cycle tables of stimulus and
// hand-computed expectations, sampled on the falling edge.
module tb_mux_4to1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_src;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux_4to1_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            $display("beat src=%0d data=%02h last=%b", out_src, out_data, out_last);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        in_data0  = 8'h5A; in_data1 = 8'h5A; in_data2 = 8'h5A; in_data3 = 8'h5A;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (out_src !== 2'd0)     begin errors++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    // Requester 2: three beats, last on 0x33, sink always ready.
    task automatic test_single_burst();
        logic [3:0] s_v   [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [7:0] s_d   [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        logic [3:0] s_l   [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] e_rdy [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       e_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_d   [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        logic       e_l   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_bsy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = s_v[c]; in_data2 = s_d[c]; in_last = s_l[c];
            @(negedge clk);
            checks++; if (in_ready !== e_rdy[c]) begin errors++; $display("FAIL single_ready c%0d: got %b want %b", c, in_ready, e_rdy[c]); end
            checks++; if (out_valid !== e_ov[c]) begin errors++; $display("FAIL single_valid c%0d: got %b want %b", c, out_valid, e_ov[c]); end
            checks++; if (busy !== e_bsy[c])     begin errors++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, e_bsy[c]); end
            if (e_ov[c]) begin
                checks++; if (out_data !== e_d[c]) begin errors++; $display("FAIL single_data c%0d: got %h want %h", c, out_data, e_d[c]); end
                checks++; if (out_last !== e_l[c]) begin errors++; $display("FAIL single_last c%0d: got %b want %b", c, out_last, e_l[c]); end
                checks++; if (out_src !== 2'd2)    begin errors++; $display("FAIL single_src c%0d: got %0d want 2", c, out_src); end
            end
        end
    endtask

    // All four requesters valid with single-beat bursts, starting from reset.
    task automatic test_round_robin();
        logic [1:0] exp_src;
        logic [3:0] exp_rdy;
        apply_reset();
        in_data0 = 8'hA0; in_data1 = 8'hA1; in_data2 = 8'hA2; in_data3 = 8'hA3;
        in_last  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 4'b1111;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready: got %b want 0000", in_ready); end
        for (int k = 0; k < 5; k++) begin
            exp_src = 2'(k);
            exp_rdy = 4'b0001 << exp_src;
            @(negedge clk);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready k%0d: got %b want %b", k, in_ready, exp_rdy); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid k%0d: got %b want 1", k, out_valid); end
            checks++; if (out_src !== exp_src) begin errors++; $display("FAIL rr_src k%0d: got %0d want %0d", k, out_src, exp_src); end
            checks++; if (out_data !== (8'hA0 + 8'(exp_src))) begin errors++; $display("FAIL rr_data k%0d: got %h want %h", k, out_data, 8'hA0 + 8'(exp_src)); end
            checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rr_last k%0d: got %b want 1", k, out_last); end
        end
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        repeat (3) @(posedge clk);
    endtask

    // Requester 1 streams six beats; MAX_BURST=4 truncates after beat 4.
    task automatic test_max_burst();
        logic [3:0] s_v   [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        logic [7:0] s_d   [9] = '{8'h51, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h55, 8'h56, 8'h00};
        logic [3:0] s_l   [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        logic [3:0] e_rdy [9] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        logic       e_ov  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] e_d   [9] = '{8'h00, 8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 8'h00, 8'h55, 8'h56};
        logic       e_l   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       e_bsy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            in_valid = s_v[c]; in_data1 = s_d[c]; in_last = s_l[c];
            @(negedge clk);
            checks++; if (in_ready !== e_rdy[c]) begin errors++; $display("FAIL maxb_ready c%0d: got %b want %b", c, in_ready, e_rdy[c]); end
            checks++; if (out_valid !== e_ov[c]) begin errors++; $display("FAIL maxb_valid c%0d: got %b want %b", c, out_valid, e_ov[c]); end
            checks++; if (busy !== e_bsy[c])     begin errors++; $display("FAIL maxb_busy c%0d: got %b want %b", c, busy, e_bsy[c]); end
            if (e_ov[c]) begin
                checks++; if (out_data !== e_d[c]) begin errors++; $display("FAIL maxb_data c%0d: got %h want %h", c, out_data, e_d[c]); end
                checks++; if (out_last !== e_l[c]) begin errors++; $display("FAIL maxb_last c%0d: got %b want %b", c, out_last, e_l[c]); end
                checks++; if (out_src !== 2'd1)    begin errors++; $display("FAIL maxb_src c%0d: got %0d want 1", c, out_src); end
            end
        end
        @(posedge clk); #1;
    endtask

    // Requester 3 bursts four beats; sink stalls for three cycles after beat 2 appears.
    task automatic test_backpressure();
        logic [3:0] s_v   [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [7:0] s_d   [10] = '{8'hC1, 8'hC1, 8'hC2, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC4, 8'h00, 8'h00};
        logic [3:0] s_l   [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic       s_or  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] e_rdy [10] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic       e_ov  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_d   [10] = '{8'h00, 8'h00, 8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC3, 8'hC4, 8'h00};
        logic       e_l   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_bsy [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = s_v[c]; in_data3 = s_d[c]; in_last = s_l[c]; out_ready = s_or[c];
            @(negedge clk);
            checks++; if (in_ready !== e_rdy[c]) begin errors++; $display("FAIL bp_ready c%0d: got %b want %b", c, in_ready, e_rdy[c]); end
            checks++; if (out_valid !== e_ov[c]) begin errors++; $display("FAIL bp_valid c%0d: got %b want %b", c, out_valid, e_ov[c]); end
            checks++; if (busy !== e_bsy[c])     begin errors++; $display("FAIL bp_busy c%0d: got %b want %b", c, busy, e_bsy[c]); end
            if (e_ov[c]) begin
                checks++; if (out_data !== e_d[c]) begin errors++; $display("FAIL bp_data c%0d: got %h want %h", c, out_data, e_d[c]); end
                checks++; if (out_last !== e_l[c]) begin errors++; $display("FAIL bp_last c%0d: got %b want %b", c, out_last, e_l[c]); end
                checks++; if (out_src !== 2'd3)    begin errors++; $display("FAIL bp_src c%0d: got %0d want 3", c, out_src); end
            end
        end
        out_ready = 1'b1;
    endtask

    // Requester 0 pauses mid-burst while requester 3 waits; grant must stay on 0.
    task automatic test_valid_gap();
        logic [3:0] s_v   [10] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [7:0] s_d   [10] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [3:0] s_l   [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] e_rdy [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic       e_ov  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] e_d   [10] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h03, 8'h00, 8'h3F, 8'h00};
        logic       e_l   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] e_src [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        logic       e_bsy [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        in_data3  = 8'h3F;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = s_v[c]; in_data0 = s_d[c]; in_last = s_l[c];
            @(negedge clk);
            checks++; if (in_ready !== e_rdy[c]) begin errors++; $display("FAIL gap_ready c%0d: got %b want %b", c, in_ready, e_rdy[c]); end
            checks++; if (out_valid !== e_ov[c]) begin errors++; $display("FAIL gap_valid c%0d: got %b want %b", c, out_valid, e_ov[c]); end
            checks++; if (busy !== e_bsy[c])     begin errors++; $display("FAIL gap_busy c%0d: got %b want %b", c, busy, e_bsy[c]); end
            if (e_ov[c]) begin
                checks++; if (out_data !== e_d[c])  begin errors++; $display("FAIL gap_data c%0d: got %h want %h", c, out_data, e_d[c]); end
                checks++; if (out_last !== e_l[c])  begin errors++; $display("FAIL gap_last c%0d: got %b want %b", c, out_last, e_l[c]); end
                checks++; if (out_src !== e_src[c]) begin errors++; $display("FAIL gap_src c%0d: got %0d want %0d", c, out_src, e_src[c]); end
            end
        end
    endtask

    // Reset lands during beat 2 of a four-beat burst from requester 0.
    task automatic test_reset_mid_burst();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 4'b0001; in_data0 = 8'h91; in_last = 4'b0000;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_idle_ready: got %b want 0000", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ready: got %b want 0001", in_ready); end
        @(posedge clk); #1;
        in_data0 = 8'h92;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h91) begin errors++; $display("FAIL rstmid_beat1: got valid=%b data=%h want 1/91", out_valid, out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL rstmid_out_data: got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL rstmid_out_last: got %b want 0", out_last); end
        checks++; if (out_src !== 2'd0)     begin errors++; $display("FAIL rstmid_out_src: got %0d want 0", out_src); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_in_ready: got %b want 0000", in_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        in_valid = 4'b0011; in_data0 = 8'hE0; in_data1 = 8'hE1; in_last = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_grant: got %b want 0001", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hE0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_first_beat: got valid=%b src=%0d data=%h last=%b want 1/0/e0/1", out_valid, out_src, out_data, out_last);
        end
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_valid_gap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
